// File: rtl/dmem_axi_if.sv
// Single-beat AXI4 data-bus bundle between one lane's dmem_axi_port (master) and the interconnect (slave).
interface dmem_axi_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              arvalid, arready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arsize;
   logic [3:0]        arid;
   logic [7:0]        arlen;
   logic [1:0]        arburst;

   logic              rvalid, rready, rlast;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   logic              awvalid, awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awsize;
   logic [3:0]        awid;
   logic [7:0]        awlen;
   logic [1:0]        awburst;

   logic                wvalid, wready, wlast;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;

   logic       bvalid, bready;
   logic [1:0] bresp;

   modport master (
      output arvalid, araddr, arsize, arid, arlen, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rlast,
      output rready,
      output awvalid, awaddr, awsize, awid, awlen, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arsize, arid, arlen, arburst,
      output arready,
      output rvalid, rdata, rresp, rlast,
      input  rready,
      input  awvalid, awaddr, awsize, awid, awlen, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp,
      input  bready
   );
endinterface

// File: rtl/dmem_axi_port.sv
// One lane's M-stage load/store turned into a single-beat AXI4 access, holding the pipeline via stall_miss.
// Optional DMEM_POSTED_WRITE_EN: stores retire after AW/W handshake; the B response is tracked in the background.
module dmem_axi_port #(
   parameter int         ADDR_W = 64,
   parameter int         DATA_W = 64,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [2:0]          req_size,
   output logic                stall_miss,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   dmem_axi_if.master          axi
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

   state_t state, state_nxt;

   logic                arvalid_q, awvalid_q, wvalid_q;
   logic                aw_done, w_done;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          size_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [1:0]          resp_q;
   logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                aw_fin, w_fin, issue_ok;
   logic                accept_rd, accept_wr;
   logic                b_pend, err_sticky;

   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arsize  = size_q;
   assign axi.arid    = AXI_ID;
   assign axi.arlen   = 8'd0;
   assign axi.arburst = 2'b01;
   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awsize  = size_q;
   assign axi.awid    = AXI_ID;
   assign axi.awlen   = 8'd0;
   assign axi.awburst = 2'b01;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = 1'b1;
   assign axi.rready  = (state == RD_DATA);
`ifdef DMEM_POSTED_WRITE_EN
   assign axi.bready  = b_pend;
`else
   assign axi.bready  = (state == WR_RESP);
`endif

   assign ar_hs  = axi.arvalid & axi.arready;
   assign r_hs   = axi.rvalid  & axi.rready;
   assign aw_hs  = axi.awvalid & axi.awready;
   assign w_hs   = axi.wvalid  & axi.wready;
   assign b_hs   = axi.bvalid  & axi.bready;
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done  | w_hs;
   // A new request may leave IDLE only once any posted write's B has arrived
   assign issue_ok = ~b_pend | axi.bvalid;

   always_comb begin
      state_nxt  = state;
      accept_rd  = 1'b0;
      accept_wr  = 1'b0;
      stall_miss = req_valid & (state != DONE);
      resp_err   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && issue_ok) begin
               accept_rd = ~req_we;
               accept_wr = req_we;
               state_nxt = req_we ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
         RD_DATA: if (r_hs) state_nxt = DONE;
         WR_REQ: begin
            if (aw_fin && w_fin) begin
`ifdef DMEM_POSTED_WRITE_EN
               state_nxt = DONE;
`else
               state_nxt = WR_RESP;
`endif
            end
         end
         WR_RESP: if (b_hs) state_nxt = DONE;
         DONE: begin
            state_nxt = IDLE;
            resp_err  = (resp_q != 2'b00) | err_sticky;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept_rd)  arvalid_q <= 1'b1;
         else if (ar_hs) arvalid_q <= 1'b0;
         if (accept_wr) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
         end else begin
            if (aw_hs) begin
               awvalid_q <= 1'b0;
               aw_done   <= 1'b1;
            end
            if (w_hs) begin
               wvalid_q <= 1'b0;
               w_done   <= 1'b1;
            end
         end
      end
   end

   // Load data is architecturally visible until the next read, so it carries a reset value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    resp_rdata <= '0;
      else if (r_hs) resp_rdata <= axi.rdata;
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         addr_q  <= req_addr;
         size_q  <= req_size;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
      if (state == IDLE)                    resp_q <= 2'b00;
      else if (r_hs)                        resp_q <= axi.rresp;
      else if (b_hs && state == WR_RESP)    resp_q <= axi.bresp;
   end

`ifdef DMEM_POSTED_WRITE_EN
   // A bad BRESP on a posted store surfaces on whichever access completes next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_pend     <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (state == WR_REQ && aw_fin && w_fin) b_pend <= 1'b1;
         else if (b_hs)                          b_pend <= 1'b0;
         if (b_hs && axi.bresp != 2'b00) err_sticky <= 1'b1;
         else if (state == DONE)         err_sticky <= 1'b0;
      end
   end
`else
   assign b_pend     = 1'b0;
   assign err_sticky = 1'b0;
`endif

   a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (state != IDLE) |-> req_valid);
   a_single_beat: assert property (@(posedge clk) disable iff (!rst_n)
      (axi.rvalid && axi.rready) |-> axi.rlast);

endmodule
